branch_target_arbiter: RTL and testbench
========================================

# branch_target_arbiter

Shares one branch-target adder between the two cores of the dual-core CPU. Each core's ID stage requests a target, computed as its PC+4 plus the sign-extended immediate shifted left two. The block arbitrates round-robin and registers the sum, returning it with a one-hot response strobe one cycle after grant. A per-core flush cancels a pending response when that core squashes the branch.

## Interface
- Parameters:
- DATA_W, 32, address/data width; shift-by-two and sum are DATA_W wide.
- Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- req_i  input  2  request per core (bit k = core k); level, held until rsp_valid_o[k].
- pc_plus4_0_i  input  DATA_W  core 0 PC+4.
- offset_0_i  input  DATA_W  core 0 sign-extended immediate (unshifted).
- pc_plus4_1_i  input  DATA_W  core 1 PC+4.
- offset_1_i  input  DATA_W  core 1 sign-extended immediate.
- flush_i  input  2  per-core cancel of that core's pending/current request.
- gnt_o  output  2  one-hot combinational grant this cycle (0 if none).
- rsp_valid_o  output  2  one-hot registered response strobe, one cycle wide.
- target_o  output  DATA_W  registered branch target, valid when rsp_valid_o != 0.
- prio_o  output  1  current round-robin pointer (core with priority on conflict).

## Operation
- Eligible[k] = req_i[k] & ~flush_i[k] & ~pend[k]; pend[k] = rsp_valid_o[k] (registered mask of last cycle's grantee).
- Grant: only one eligible → grant it; both eligible → grant core prio_o; none → gnt_o = 2'b00.
- On grant to k: target_o <= pc_plus4_k + {offset_k[DATA_W-3:0], 2'b00}, modulo 2^DATA_W (carry discarded, no overflow flag); rsp_valid_o <= one-hot(k).
- No grant: rsp_valid_o <= 0; target_o holds last value.
- Pointer: after a grant to k, prio_o <= ~k (priority to the other core); unchanged when no grant.
- Flush: flush_i[k] high in grant cycle suppresses grant to k (other core may take the slot same cycle). flush_i[k] high in response cycle forces rsp_valid_o[k] to 0 combinationally at output (target_o unaffected); pointer update already taken stands.
- Masking: a core whose response is on rsp_valid_o this cycle is ineligible this cycle, so a requester dropping req_i one cycle late is never double-served.

## Timing
- Reset (rst_i = 0 at edge): rsp_valid_o = 2'b00, target_o = 0, prio_o = 0, pend = 0; gnt_o = 0 while rst_i low.
- Latency: grant in cycle N → rsp_valid_o/target_o valid in N+1, exactly one cycle.
- Throughput: one target per cycle aggregate; each core at most one per two cycles (masking), so under continuous contention service alternates 0,1,0,1.
- Reset asserted with response pending: response discarded, outputs reset next edge.
- Inputs sampled only in the grant cycle; changes after grant do not affect target_o.

## Test plan
- Reset: hold rst_i=0 with req_i=2'b11 → gnt_o=0, rsp_valid_o=0, target_o=0, prio_o=0.
- Single request: core 0, pc_plus4=0x0000_1004, offset=0x0000_0003 → gnt_o=01 in N, N+1 rsp_valid_o=01, target_o=0x0000_1010, prio_o=1.
- Negative offset/wrap: core 1, pc_plus4=0x0000_0004, offset=0xFFFF_FFFE → target_o=0xFFFF_FFFC. Also pc_plus4=0xFFFF_FFFC, offset=2 → target_o=0x0000_0004 (carry dropped).
- Contention: req_i=11 held 4 cycles from reset → grants 01,10,01,10; responses follow one cycle later with the matching per-core targets.
- Late drop: core 0 alone, holds req_i one cycle after rsp_valid_o[0] → no second grant that cycle; exactly one response.
- Flush: req_i=11, prio_o=0, flush_i=01 → gnt_o=10. Separately, flush_i[1] in a core-1 response cycle → rsp_valid_o=00 that cycle.

Source files
------------

// File: rtl/branch_target_arbiter.sv
// branch_target_arbiter
// Shares one branch-target adder between two cores. Each core requests
// pc_plus4 + (offset << 2). A round-robin pointer decides conflicts, the
// sum is registered, and a one-hot strobe returns it one cycle after grant.
// A core whose response is on the strobe this cycle is masked from winning
// again, so a requester that drops req_i one cycle late is never served twice.
module branch_target_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [DATA_W-1:0] pc_plus4_0_i,
  input  logic [DATA_W-1:0] offset_0_i,
  input  logic [DATA_W-1:0] pc_plus4_1_i,
  input  logic [DATA_W-1:0] offset_1_i,
  input  logic [1:0]        flush_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rsp_valid_o,
  output logic [DATA_W-1:0] target_o,
  output logic              prio_o
);

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              prio_q, prio_d;

  logic [1:0]        eligible;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] sum_0;
  logic [DATA_W-1:0] sum_1;

  // Both candidate targets; the shift drops the top two offset bits and the
  // add wraps modulo 2^DATA_W with the carry discarded.
  always_comb begin
    sum_0 = pc_plus4_0_i + (offset_0_i << 2);
    sum_1 = pc_plus4_1_i + (offset_1_i << 2);
  end

  // Eligibility and round-robin grant; nothing is granted while in reset.
  always_comb begin
    eligible = req_i & ~flush_i & ~rsp_valid_q;
    gnt      = 2'b00;
    if (rst_i) begin
      case (eligible)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Next-state for the response register, held target and priority pointer.
  always_comb begin
    rsp_valid_d = 2'b00;
    target_d    = target_q;
    prio_d      = prio_q;
    if (gnt[0]) begin
      rsp_valid_d = 2'b01;
      target_d    = sum_0;
      prio_d      = 1'b1;
    end else if (gnt[1]) begin
      rsp_valid_d = 2'b10;
      target_d    = sum_1;
      prio_d      = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; a pending response is
  // simply dropped when reset is taken.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rsp_valid_q <= 2'b00;
      target_q    <= '0;
      prio_q      <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      target_q    <= target_d;
      prio_q      <= prio_d;
    end
  end

  // Outputs; a flush during the response cycle hides that core's strobe only.
  always_comb begin
    gnt_o       = gnt;
    rsp_valid_o = rsp_valid_q & ~flush_i;
    target_o    = target_q;
    prio_o      = prio_q;
  end

endmodule

// File: tb/tb_branch_target_arbiter.sv
// Directed testbench for branch_target_arbiter. Each step drives one cycle
// of inputs; the expected response for that cycle is pushed to a scoreboard
// and popped one cycle later when the registered outputs should show it.
module tb_branch_target_arbiter;

  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        req_i;
  logic [DATA_W-1:0] pc_plus4_0_i;
  logic [DATA_W-1:0] offset_0_i;
  logic [DATA_W-1:0] pc_plus4_1_i;
  logic [DATA_W-1:0] offset_1_i;
  logic [1:0]        flush_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rsp_valid_o;
  logic [DATA_W-1:0] target_o;
  logic              prio_o;

  typedef struct {
    logic [1:0]        rsp;
    logic [DATA_W-1:0] tgt;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] last_target = '0;
  int                errors = 0;
  int                checks = 0;

  branch_target_arbiter #(.DATA_W(DATA_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .pc_plus4_0_i (pc_plus4_0_i),
    .offset_0_i   (offset_0_i),
    .pc_plus4_1_i (pc_plus4_1_i),
    .offset_1_i   (offset_1_i),
    .flush_i      (flush_i),
    .gnt_o        (gnt_o),
    .rsp_valid_o  (rsp_valid_o),
    .target_o     (target_o),
    .prio_o       (prio_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Pop the response expected for this cycle and compare the registered outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    logic [1:0] exp_rsp;
    if (sb_q.size() != 0) begin
      e       = sb_q.pop_front();
      exp_rsp = e.rsp & ~flush_i;
      checks++;
      assert (rsp_valid_o === exp_rsp) else begin
        errors++;
        $error("[TB] FAIL %s rsp_valid_o: got %b expected %b", tag, rsp_valid_o, exp_rsp);
      end
      checks++;
      assert (target_o === e.tgt) else begin
        errors++;
        $error("[TB] FAIL %s target_o: got %h expected %h", tag, target_o, e.tgt);
      end
    end
  endtask

  // Drive one cycle, check grant and pointer, and record the expected response.
  task automatic applyStimulus(
    input string             tag,
    input logic              rst,
    input logic [1:0]        req,
    input logic [1:0]        flush,
    input logic [DATA_W-1:0] pc0,
    input logic [DATA_W-1:0] off0,
    input logic [DATA_W-1:0] pc1,
    input logic [DATA_W-1:0] off1,
    input logic [1:0]        exp_gnt,
    input logic              exp_prio
  );
    exp_t e;
    @(negedge clk_i);
    rst_i        = rst;
    req_i        = req;
    flush_i      = flush;
    pc_plus4_0_i = pc0;
    offset_0_i   = off0;
    pc_plus4_1_i = pc1;
    offset_1_i   = off1;
    #1;
    checkOutput(tag);
    checks++;
    assert (gnt_o === exp_gnt) else begin
      errors++;
      $error("[TB] FAIL %s gnt_o: got %b expected %b", tag, gnt_o, exp_gnt);
    end
    checks++;
    assert (prio_o === exp_prio) else begin
      errors++;
      $error("[TB] FAIL %s prio_o: got %b expected %b", tag, prio_o, exp_prio);
    end
    if (!rst) begin
      last_target = '0;
      e.rsp       = 2'b00;
    end else if (exp_gnt == 2'b01) begin
      last_target = pc0 + (off0 << 2);
      e.rsp       = 2'b01;
    end else if (exp_gnt == 2'b10) begin
      last_target = pc1 + (off1 << 2);
      e.rsp       = 2'b10;
    end else begin
      e.rsp       = 2'b00;
    end
    e.tgt = last_target;
    sb_q.push_back(e);
  endtask

  // Directed sequence; expected grant and pointer values are worked out by hand.
  initial begin
    rst_i = 1'b0; req_i = 2'b00; flush_i = 2'b00;
    pc_plus4_0_i = '0; offset_0_i = '0; pc_plus4_1_i = '0; offset_1_i = '0;

    // Reset held with both cores requesting.
    applyStimulus("reset0", 1'b0, 2'b11, 2'b00, 32'h100, 32'h1, 32'h200, 32'h2, 2'b00, 1'b0);
    sb_q.delete();
    sb_q.push_back('{rsp: 2'b00, tgt: '0});
    applyStimulus("reset1", 1'b0, 2'b11, 2'b00, 32'h100, 32'h1, 32'h200, 32'h2, 2'b00, 1'b0);

    // Continuous contention alternates 0,1,0,1.
    applyStimulus("cont0", 1'b1, 2'b11, 2'b00, 32'h100, 32'h1, 32'h200, 32'h2, 2'b01, 1'b0);
    applyStimulus("cont1", 1'b1, 2'b11, 2'b00, 32'h100, 32'h1, 32'h200, 32'h2, 2'b10, 1'b1);
    applyStimulus("cont2", 1'b1, 2'b11, 2'b00, 32'h100, 32'h1, 32'h200, 32'h2, 2'b01, 1'b0);
    applyStimulus("cont3", 1'b1, 2'b11, 2'b00, 32'h100, 32'h1, 32'h200, 32'h2, 2'b10, 1'b1);
    applyStimulus("idle0", 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Single core-0 request, then a late drop of req_i.
    applyStimulus("single", 1'b1, 2'b01, 2'b00, 32'h0000_1004, 32'h0000_0003, 32'h0, 32'h0, 2'b01, 1'b0);
    applyStimulus("late",   1'b1, 2'b01, 2'b00, 32'h0000_1004, 32'h0000_0003, 32'h0, 32'h0, 2'b00, 1'b1);
    applyStimulus("hold",   1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1);

    // Negative offset, then carry out of the top bit dropped.
    applyStimulus("neg",   1'b1, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0000_0004, 32'hFFFF_FFFE, 2'b10, 1'b1);
    applyStimulus("idle1", 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyStimulus("wrap",  1'b1, 2'b10, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0002, 2'b10, 1'b0);
    applyStimulus("idle2", 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Flush core 0 in the grant cycle; flush core 1 in its response cycle.
    applyStimulus("flushg", 1'b1, 2'b11, 2'b01, 32'h4000, 32'h1, 32'h3000, 32'h10, 2'b10, 1'b0);
    applyStimulus("flushr", 1'b1, 2'b00, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Reset taken while a response is pending.
    applyStimulus("pend",   1'b1, 2'b01, 2'b00, 32'h5000, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0);
    applyStimulus("rstpnd", 1'b0, 2'b11, 2'b00, 32'h100, 32'h1, 32'h200, 32'h2, 2'b00, 1'b1);
    applyStimulus("after",  1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyStimulus("final",  1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
